// File: rtl/regfile_scoreboard_if.sv
// Decode-stage register file bundle: writeback, read ports, issue and scoreboard status.
// The master side drives writeback, read and issue requests; the slave side returns data and hazard status.
interface regfile_scoreboard_if #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_READ = 2
);
  localparam int AW = $clog2(NUM_REGS);

  logic                     we;
  logic [AW-1:0]            waddr;
  logic [XLEN-1:0]          wdata;
  logic [NUM_READ*AW-1:0]   raddr;
  logic [NUM_READ-1:0]      ruse;
  logic [NUM_READ*XLEN-1:0] rdata;
  logic                     iss_valid;
  logic [AW-1:0]            iss_rd;
  logic                     flush;
  logic                     stall;
  logic [NUM_REGS-1:0]      pending;
  logic [AW:0]              busy_count;

  modport master (
    output we, waddr, wdata, raddr, ruse, iss_valid, iss_rd, flush,
    input  rdata, stall, pending, busy_count
  );

  modport slave (
    input  we, waddr, wdata, raddr, ruse, iss_valid, iss_rd, flush,
    output rdata, stall, pending, busy_count
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Parametrised ID-stage register file with write-to-read bypass and a per-register
// pending scoreboard that stalls decode on RAW/WAW hazards against in-flight producers.
module regfile_scoreboard #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_READ = 2
) (
  input logic                 clk,
  input logic                 reset,
  regfile_scoreboard_if.slave bus
);
  localparam int AW = $clog2(NUM_REGS);
  localparam logic [NUM_REGS-1:0] ONE_HOT0 = {{(NUM_REGS-1){1'b0}}, 1'b1};

  logic [XLEN-1:0]          regs_r [NUM_REGS];
  logic [NUM_REGS-1:0]      pending_r;
  logic [AW:0]              busy_r;

  logic [AW-1:0]            ra_s [NUM_READ];
  logic [NUM_READ*XLEN-1:0] rdata_s;
  logic                     wr_en_s;
  logic                     raw_s;
  logic                     waw_s;
  logic                     stall_s;
  logic                     iss_take_s;
  logic [NUM_REGS-1:0]      clr_mask_s;
  logic [NUM_REGS-1:0]      set_mask_s;
  logic [NUM_REGS-1:0]      pending_next_s;

  function automatic logic [AW:0] popcount(input logic [NUM_REGS-1:0] v);
    logic [AW:0] c;
    c = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      c = c + {{AW{1'b0}}, v[i]};
    end
    return c;
  endfunction

  assign wr_en_s = bus.we && (bus.waddr != {AW{1'b0}});

  // Split the packed read-address bus into per-port addresses.
  always_comb begin
    for (int k = 0; k < NUM_READ; k++) begin
      ra_s[k] = bus.raddr[k*AW +: AW];
    end
  end

  // Per-port read mux with bypass, plus RAW hazard detection; a same-cycle writeback resolves the hazard.
  always_comb begin
    rdata_s = '0;
    raw_s   = 1'b0;
    for (int k = 0; k < NUM_READ; k++) begin
      if (!reset) begin
        rdata_s[k*XLEN +: XLEN] = {XLEN{1'b0}};
      end else if (ra_s[k] == {AW{1'b0}}) begin
        rdata_s[k*XLEN +: XLEN] = {XLEN{1'b0}};
      end else if (wr_en_s && (bus.waddr == ra_s[k])) begin
        rdata_s[k*XLEN +: XLEN] = bus.wdata;
      end else begin
        rdata_s[k*XLEN +: XLEN] = regs_r[ra_s[k]];
      end
      raw_s = raw_s | (bus.ruse[k] && (ra_s[k] != {AW{1'b0}}) && pending_r[ra_s[k]]
                       && !(wr_en_s && (bus.waddr == ra_s[k])));
    end
  end

  // WAW hazard, stall and scoreboard next state; set beats clear on the same register.
  always_comb begin
    waw_s      = bus.iss_valid && (bus.iss_rd != {AW{1'b0}}) && pending_r[bus.iss_rd]
                 && !(wr_en_s && (bus.waddr == bus.iss_rd));
    stall_s    = reset && !bus.flush && (raw_s || waw_s);
    iss_take_s = bus.iss_valid && !stall_s && (bus.iss_rd != {AW{1'b0}});
    clr_mask_s = wr_en_s    ? (ONE_HOT0 << bus.waddr)  : {NUM_REGS{1'b0}};
    set_mask_s = iss_take_s ? (ONE_HOT0 << bus.iss_rd) : {NUM_REGS{1'b0}};
    if (bus.flush) begin
      pending_next_s = {NUM_REGS{1'b0}};
    end else begin
      pending_next_s = ((pending_r & ~clr_mask_s) | set_mask_s) & ~ONE_HOT0;
    end
  end

  // Register array: x0 is never written, so it stays zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else if (wr_en_s) begin
      regs_r[bus.waddr] <= bus.wdata;
    end
  end

  // Scoreboard state and its population count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_r <= {NUM_REGS{1'b0}};
      busy_r    <= {(AW+1){1'b0}};
    end else begin
      pending_r <= pending_next_s;
      busy_r    <= popcount(pending_next_s);
    end
  end

  assign bus.rdata      = rdata_s;
  assign bus.stall      = stall_s;
  assign bus.pending    = pending_r;
  assign bus.busy_count = busy_r;
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the decode-stage register file: configurable data width, register count and read-port count.
- Adds same-cycle write-to-read bypass and a per-register pending (scoreboard) bit.
- Drives a decode-stage stall on RAW and WAW hazards against in-flight producers.
- Sits in ID: read ports feed operand latches, the write port is driven from WB, the issue port is driven when ID hands an instruction to EX.

Parameters:
XLEN, 32, data width of each register.
NUM_REGS, 32, number of architectural registers; power of two, >=2; register 0 hardwired to zero.
NUM_READ, 2, number of independent read ports (1..4).
AW, $clog2(NUM_REGS), address width (derived, not overridden).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
we  in  1  writeback enable.
waddr  in  AW  writeback destination.
wdata  in  XLEN  writeback data.
raddr  in  NUM_READ*AW  read addresses; port k at [k*AW +: AW].
ruse  in  NUM_READ  port k operand is actually consumed by the decoding instruction.
rdata  out  NUM_READ*XLEN  read data; port k at [k*XLEN +: XLEN].
iss_valid  in  1  instruction leaves ID this cycle.
iss_rd  in  AW  destination of the issuing instruction (0 = no destination).
flush  in  1  pipeline flush; discards all pending producers.
stall  out  1  ID must hold; hazard against a pending register.
pending  out  NUM_REGS  scoreboard bit vector; bit 0 always 0.
busy_count  out  AW+1  population count of pending.

Behaviour:
- Reset (reset=0, asynchronous): all registers cleared to 0, all pending bits cleared. While in reset: rdata=0, stall=0, busy_count=0. Deassertion is synchronised by the integrator; the block treats it as async.
- Reads are combinational, zero latency:
  - raddr==0 -> rdata=0.
  - else if we && waddr==raddr && waddr!=0 -> rdata=wdata (bypass).
  - else -> stored value.
- Write: on rising edge with we=1 and waddr!=0, register waddr <= wdata. A write to x0 is silently dropped, with no state change. A write is visible in the array from the next cycle and via bypass in the same cycle.
- Scoreboard updates, evaluated at rising edge in this priority:
  1. flush=1 -> all pending bits cleared; same-cycle iss_valid is ignored; the register write still occurs.
  2. Clear: we=1 and waddr!=0 -> pending[waddr] <= 0.
  3. Set: iss_valid=1, stall=0, iss_rd!=0 -> pending[iss_rd] <= 1. When set and clear hit the same register in one cycle, set wins, so the bit is 1.
- pending[0] is never set.
- stall, combinational: asserted if any port k has ruse[k]=1, raddr_k!=0, pending[raddr_k]=1 and not (we && waddr==raddr_k). That is the RAW case; the bypass resolves the hazard in the writeback cycle.
- stall is also asserted if iss_valid=1, iss_rd!=0, pending[iss_rd]=1 and not (we && waddr==iss_rd). That is the WAW case, which guarantees at most one outstanding producer per register.
- stall is forced 0 when flush=1.
- While stall=1, iss_valid is not honoured: no pending bit is set.
- busy_count equals the popcount of the registered pending vector. It is updated one cycle after set/clear and ranges 0..NUM_REGS-1.
- A writeback to a non-pending register is legal: data is written, the pending bit stays 0.
- A mid-operation reset discards all data and pending state immediately, without waiting for a clock edge.
- Every read port applies the identical bypass/stall rule independently; multiple ports reading the same address are legal.

Test Plan:
1. Reset then read: assert reset=0 for 3 cycles, release; read x5 on both ports -> rdata=0x00000000, stall=0, pending=0, busy_count=0.
2. Write/bypass: we=1, waddr=7, wdata=0xDEADBEEF, raddr0=7 in the same cycle -> rdata0=0xDEADBEEF immediately; next cycle with we=0 -> still 0xDEADBEEF.
3. x0 write: we=1, waddr=0, wdata=0x12345678; next cycle raddr0=0 -> rdata0=0, pending[0]=0.
4. RAW: issue iss_rd=3; next cycle raddr1=3, ruse[1]=1 -> stall=1, busy_count=1. Hold 2 cycles, then we=1, waddr=3, wdata=0xA5 -> stall=0 that cycle and rdata1=0xA5; the following cycle pending[3]=0, busy_count=0. With ruse[1]=0 and raddr1=3 -> stall=0.
5. Set/clear collision and WAW: pending[4]=1; drive we=1, waddr=4 with iss_valid=1, iss_rd=4 -> stall=0, and after the edge pending[4]=1. Separately, with pending[9]=1 and no writeback, iss_rd=9 -> stall=1 and pending unchanged.
6. Flush and async reset: set pending for x1, x2, x3 (busy_count=3), then flush=1 with iss_valid=1, iss_rd=5 -> next cycle pending=0. Re-set x1, then pulse reset=0 mid-cycle with no clock edge -> pending and all registers are 0 immediately.
